alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU core.
// One operation is in flight at a time: IDLE (grant/accept) -> EXEC (drive
// the core, capture its result) -> RESP (hold the result for the owner).
module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_sel,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_sel,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,

    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,

    output logic [4:0]  alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0] SEL_NOP = 5'h0F;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [4:0]  sel_q, sel_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;

    logic        gnt_vld;
    logic        gnt_id;

    // Grant decision, purely from the current request valids and last winner
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
            gnt_id = ~req0_valid;
        end
    end

    // Next-state and output decode; ready is only offered to the granted
    // port while IDLE, so a granted port with valid high is an accept
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        sel_d        = sel_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        resp0_result = 32'h0;
        resp1_result = 32'h0;
        alu_sel      = SEL_NOP;
        alu_a        = 32'h0;
        alu_b        = 32'h0;
        busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                req0_ready = gnt_vld & ~gnt_id;
                req1_ready = gnt_vld &  gnt_id;
                if (gnt_vld) begin
                    state_d      = EXEC;
                    owner_d      = gnt_id;
                    last_grant_d = gnt_id;
                    sel_d        = gnt_id ? req1_sel : req0_sel;
                    a_d          = gnt_id ? req1_a   : req0_a;
                    b_d          = gnt_id ? req1_b   : req0_b;
                end
            end
            EXEC: begin
                alu_sel = sel_q;
                alu_a   = a_q;
                alu_b   = b_q;
                res_d   = alu_result;
                state_d = RESP;
            end
            RESP: begin
                // The other port's resp ready plays no part here
                if (owner_q) begin
                    resp1_valid  = 1'b1;
                    resp1_result = res_q;
                    if (resp1_ready) state_d = IDLE;
                end else begin
                    resp0_valid  = 1'b1;
                    resp0_result = res_q;
                    if (resp0_ready) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    // and makes port 0 the winner of the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            sel_q        <= 5'h0;
            a_q          <= 32'h0;
            b_q          <= 32'h0;
            res_q        <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            sel_q        <= sel_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance is driven through a
// vector table and corner-case sequences; a fixed-priority instance shares
// the request/response inputs and is examined in its own sequence.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_sel, req1_sel;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_ready, resp1_ready;

    logic        req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
    logic [31:0] resp0_result, resp1_result, alu_a, alu_b, alu_result;
    logic [4:0]  alu_sel;

    logic        f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid, f_busy;
    logic [31:0] f_resp0_result, f_resp1_result, f_alu_a, f_alu_b, f_alu_result;
    logic [4:0]  f_alu_sel;

    int checks = 0;
    int errors = 0;

    // Stand-in for the shared ALU core: ADD, SUB, XOR; everything else gives 0
    function automatic logic [31:0] alu_core(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            5'h02:   return a + b;
            5'h03:   return a - b;
            5'h06:   return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result   = alu_core(alu_sel, alu_a, alu_b);
    assign f_alu_result = alu_core(f_alu_sel, f_alu_a, f_alu_b);

    alu_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .busy(busy)
    );

    alu_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(f_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(f_resp0_result),
        .resp1_valid(f_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(f_resp1_result),
        .alu_sel(f_alu_sel), .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_result(f_alu_result),
        .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        port;
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic port, input logic v, input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        if (port) begin
            req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
        end
    endtask

    // One complete operation on one port with both resp readies high
    task automatic run_op(input string tag, input logic port, input logic [4:0] s,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        logic rdy;
        int   n;
        drive(port, 1'b1, s, a, b);
        #1;
        rdy = port ? req1_ready : req0_ready;
        n = 0;
        while (!rdy && n < 10) begin
            tick();
            rdy = port ? req1_ready : req0_ready;
            n++;
        end
        check({tag, " ready"}, {31'h0, rdy}, 32'h1);
        if (!rdy) begin
            drive(port, 1'b0, 5'h0, 32'h0, 32'h0);
            return;
        end
        tick();                                   // accepting edge
        drive(port, 1'b0, 5'h0, 32'h0, 32'h0);
        check({tag, " exec busy"}, {31'h0, busy}, 32'h1);
        check({tag, " exec alu_sel"}, {27'h0, alu_sel}, {27'h0, s});
        check({tag, " exec alu_a"}, alu_a, a);
        check({tag, " exec alu_b"}, alu_b, b);
        check({tag, " exec resp_valid"}, {31'h0, port ? resp1_valid : resp0_valid}, 32'h0);
        tick();                                   // second edge: response up
        check({tag, " resp_valid"}, {31'h0, port ? resp1_valid : resp0_valid}, 32'h1);
        check({tag, " resp_result"}, port ? resp1_result : resp0_result, res);
        check({tag, " other valid"}, {31'h0, port ? resp0_valid : resp1_valid}, 32'h0);
        check({tag, " other result"}, port ? resp0_result : resp1_result, 32'h0);
        check({tag, " resp alu_sel"}, {27'h0, alu_sel}, 32'h0F);
        tick();                                   // response handshake
        check({tag, " idle busy"}, {31'h0, busy}, 32'h0);
        check({tag, " idle result"}, port ? resp1_result : resp0_result, 32'h0);
    endtask

    initial begin
        int   grants;
        logic seen1, seenr1;

        tbl[0] = '{port: 1'b0, sel: 5'h02, a: 32'd5,          b: 32'd7,          res: 32'd12};
        tbl[1] = '{port: 1'b1, sel: 5'h03, a: 32'd10,         b: 32'd3,          res: 32'd7};
        tbl[2] = '{port: 1'b0, sel: 5'h06, a: 32'h000000F0,   b: 32'h0000000F,   res: 32'h000000FF};
        tbl[3] = '{port: 1'b1, sel: 5'h1F, a: 32'hFFFFFFFF,   b: 32'h00000001,   res: 32'h0};
        tbl[4] = '{port: 1'b0, sel: 5'h02, a: 32'hFFFFFFFF,   b: 32'h00000001,   res: 32'h0};
        tbl[5] = '{port: 1'b1, sel: 5'h02, a: 32'h12345678,   b: 32'h11111111,   res: 32'h23456789};

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_sel = 5'h0; req0_a = 32'h0; req0_b = 32'h0;
        req1_valid = 1'b0; req1_sel = 5'h0; req1_a = 32'h0; req1_b = 32'h0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;

        // Reset state
        tick();
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst alu_sel", {27'h0, alu_sel}, 32'h0F);
        check("rst alu_a", alu_a, 32'h0);
        check("rst resp0_valid", {31'h0, resp0_valid}, 32'h0);
        check("rst resp1_valid", {31'h0, resp1_valid}, 32'h0);
        check("rst resp1_result", resp1_result, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Vector table: single-port operations
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].port, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].res);
        end

        // Both ports requesting continuously: port 0 first, then alternate
        do_reset();
        drive(1'b0, 1'b1, 5'h03, 32'd10, 32'd3);
        drive(1'b1, 1'b1, 5'h06, 32'h000000F0, 32'h0000000F);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr%0d req0_ready", i), {31'h0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("rr%0d req1_ready", i), {31'h0, req1_ready}, (i % 2 == 1) ? 32'h1 : 32'h0);
            tick();
            check($sformatf("rr%0d exec ready", i), {30'h0, req0_ready, req1_ready}, 32'h0);
            tick();
            check($sformatf("rr%0d resp_valid", i), {30'h0, resp1_valid, resp0_valid}, (i % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("rr%0d result", i), (i % 2 == 0) ? resp0_result : resp1_result, (i % 2 == 0) ? 32'd7 : 32'hFF);
            check($sformatf("rr%0d resp ready", i), {30'h0, req0_ready, req1_ready}, 32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 5'h0, 32'h0, 32'h0);
        tick();

        // Response back-pressure on port 0 with port 1 waiting
        do_reset();
        resp0_ready = 1'b0;
        drive(1'b0, 1'b1, 5'h02, 32'd5, 32'd7);
        tick();                                   // accept port 0
        drive(1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 5'h02, 32'd1, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d resp0_valid", i), {31'h0, resp0_valid}, 32'h1);
            check($sformatf("bp%0d resp0_result", i), resp0_result, 32'd12);
            check($sformatf("bp%0d busy", i), {31'h0, busy}, 32'h1);
            check($sformatf("bp%0d req ready", i), {30'h0, req0_ready, req1_ready}, 32'h0);
            tick();
        end
        resp0_ready = 1'b1;
        tick();
        check("bp release busy", {31'h0, busy}, 32'h0);
        check("bp release req1_ready", {31'h0, req1_ready}, 32'h1);
        drive(1'b1, 1'b0, 5'h0, 32'h0, 32'h0);
        tick();

        // The non-owner's resp ready must not complete the response
        do_reset();
        resp0_ready = 1'b1;
        resp1_ready = 1'b0;
        drive(1'b1, 1'b1, 5'h02, 32'd1, 32'd2);
        tick();
        drive(1'b1, 1'b0, 5'h0, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        check("own resp1_valid", {31'h0, resp1_valid}, 32'h1);
        check("own resp1_result", resp1_result, 32'd3);
        check("own resp0_valid", {31'h0, resp0_valid}, 32'h0);
        resp1_ready = 1'b1;
        tick();
        check("own release busy", {31'h0, busy}, 32'h0);

        // Reset during EXEC discards the operation
        drive(1'b0, 1'b1, 5'h02, 32'd5, 32'd7);
        tick();
        drive(1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
        check("rx exec alu_sel", {27'h0, alu_sel}, 32'h02);
        rst_n = 1'b0;
        #1;
        check("rx alu_sel", {27'h0, alu_sel}, 32'h0F);
        check("rx busy", {31'h0, busy}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rx%0d no resp", i), {30'h0, resp1_valid, resp0_valid}, 32'h0);
            check($sformatf("rx%0d alu_sel", i), {27'h0, alu_sel}, 32'h0F);
            tick();
        end
        run_op("rx next", 1'b1, 5'h03, 32'd100, 32'd1, 32'd99);

        // Fixed-priority instance: both valid for four operations
        do_reset();
        drive(1'b0, 1'b1, 5'h02, 32'd5, 32'd7);
        drive(1'b1, 1'b1, 5'h03, 32'd10, 32'd3);
        grants = 0;
        seen1  = 1'b0;
        seenr1 = 1'b0;
        for (int n = 0; n < 40 && grants < 4; n++) begin
            #1;
            if (f_req1_ready) seen1 = 1'b1;
            if (f_resp1_valid) seenr1 = 1'b1;
            if (f_req0_ready) grants++;
            if (f_resp0_valid) check("fp resp0_result", f_resp0_result, 32'd12);
            tick();
        end
        check("fp port0 grants", grants, 32'd4);
        check("fp req1_ready seen", {31'h0, seen1}, 32'h0);
        check("fp resp1_valid seen", {31'h0, seenr1}, 32'h0);
        drive(1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 5'h0, 32'h0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
